// File: rtl/coefficient_decoder.sv
// coefficient_decoder
// Sits directly behind the Huffman symbol decoder. It selects the Huffman
// table, takes (run, size) symbols and then reads the appended magnitude
// bits from the shared serial bitstream. It also sign-extends magnitudes,
// applies DC prediction and expands zero runs, ZRL and EOB. Each 8x8 block
// produces exactly 64 zigzag-ordered coefficients, at most one per cycle.
//
// Bit handshake: a bitstream bit transfers on a rising clk edge only when
// is_new && bit_ready. While bit_ready is 0 the bit is left in place for a
// later cycle. In the symbol states the same transfer is forwarded to the
// Huffman decoder as huff_bit_en. In the magnitude states the block consumes
// the bit itself.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   next_bit, is_new    serial bit and its valid
//   bit_ready           this block takes a bit this cycle
//   huff_bit_en         is_new forwarded to the Huffman decoder (symbol states)
//   ac_dc_flag          Huffman table select, 1 = DC, 0 = AC
//   huff_done           Huffman decoder has a symbol on the current bit
//   huff_s, huff_r      run length / magnitude bit length of that symbol
//   dc_pred_clr         zero the DC predictor (acted on only in DC_SYM)
//   coef_valid          coef_index / coef_value valid (registered)
//   coef_index          zigzag index 0..63
//   coef_value          signed coefficient
//   block_done          pulse with the k=63 coefficient
//   error               sticky decode error, cleared only by rst
//   state_dbg           current FSM state encoding
module coefficient_decoder #(
  parameter int COEF_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_bit,
  input  logic                     is_new,
  output logic                     bit_ready,
  output logic                     huff_bit_en,
  output logic                     ac_dc_flag,
  input  logic                     huff_done,
  input  logic [3:0]               huff_s,
  input  logic [3:0]               huff_r,
  input  logic                     dc_pred_clr,
  output logic                     coef_valid,
  output logic [5:0]               coef_index,
  output logic signed [COEF_W-1:0] coef_value,
  output logic                     block_done,
  output logic                     error,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    DC_SYM   = 3'd0,
    AC_SYM   = 3'd1,
    DC_MAG   = 3'd2,
    AC_MAG   = 3'd3,
    ZERO_RUN = 3'd4,
    EOB_FILL = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [5:0]        k, k_nxt;
  logic [COEF_W-1:0] pred, pred_nxt;
  logic [3:0]        sym_r, sym_r_nxt;
  // Holds at most the first r-1 magnitude bits; the r-th comes straight off next_bit.
  logic [9:0]        mag, mag_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [4:0]        zrem, zrem_nxt;

  logic              cv_nxt, bd_nxt, err_nxt;
  logic [5:0]        ci_nxt;
  logic [COEF_W-1:0] cval_nxt;

  logic              take;
  logic [10:0]       shifted;
  logic              last_bit;
  logic [COEF_W-1:0] mag_val;
  logic [6:0]        k_plus_s;
  logic [COEF_W-1:0] dc_sum;

  // Magnitude category decode: a leading 1 means a positive value. Otherwise
  // the value is negative and equals v - (2^r - 1).
  function automatic logic [COEF_W-1:0] mag_decode(input logic [10:0] v,
                                                   input logic [3:0]  r);
    logic [COEF_W-1:0] ext;
    logic [COEF_W-1:0] span;
    logic [10:0]       sel;
    ext  = COEF_W'(v);
    span = (COEF_W'(1) << r) - COEF_W'(1);
    sel  = 11'd1 << (r - 4'd1);
    if ((v & sel) != 11'd0) mag_decode = ext;
    else                    mag_decode = ext - span;
  endfunction

  assign bit_ready   = (state == DC_SYM) || (state == AC_SYM) ||
                       (state == DC_MAG) || (state == AC_MAG);
  assign huff_bit_en = is_new && ((state == DC_SYM) || (state == AC_SYM));
  assign ac_dc_flag  = (state == DC_SYM) || (state == DC_MAG);
  assign state_dbg   = state;

  assign take     = is_new && bit_ready;
  assign shifted  = {mag, next_bit};
  assign last_bit = ((bit_cnt + 4'd1) == sym_r);
  assign mag_val  = mag_decode(shifted, sym_r);
  assign k_plus_s = {1'b0, k} + {3'b000, huff_s};
  assign dc_sum   = pred + mag_val;

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    pred_nxt    = pred;
    sym_r_nxt   = sym_r;
    mag_nxt     = mag;
    bit_cnt_nxt = bit_cnt;
    zrem_nxt    = zrem;
    cv_nxt      = 1'b0;
    bd_nxt      = 1'b0;
    ci_nxt      = coef_index;
    cval_nxt    = coef_value;
    err_nxt     = error;

    case (state)
      DC_SYM: begin
        if (dc_pred_clr) pred_nxt = '0;
        if (is_new && huff_done) begin
          sym_r_nxt   = huff_r;
          mag_nxt     = '0;
          bit_cnt_nxt = '0;
          if (huff_r > 4'd11) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end else if (huff_r == 4'd0) begin
            // Zero difference: emit the (possibly just cleared) predictor.
            cv_nxt    = 1'b1;
            ci_nxt    = 6'd0;
            cval_nxt  = pred_nxt;
            k_nxt     = 6'd1;
            state_nxt = AC_SYM;
          end else begin
            state_nxt = DC_MAG;
          end
        end
      end

      AC_SYM: begin
        if (is_new && huff_done) begin
          sym_r_nxt   = huff_r;
          mag_nxt     = '0;
          bit_cnt_nxt = '0;
          if ((huff_r > 4'd10) || (k_plus_s > 7'd63)) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end else if ((huff_s == 4'd0) && (huff_r == 4'd0)) begin
            state_nxt = EOB_FILL;
          end else if (huff_r == 4'd0) begin
            // ZRL (s=15) gives 16 zeros. Any other zero-size symbol also
            // gives s+1 zeros, because its value slot is itself a zero.
            zrem_nxt  = {1'b0, huff_s} + 5'd1;
            state_nxt = ZERO_RUN;
          end else if (huff_s != 4'd0) begin
            zrem_nxt  = {1'b0, huff_s};
            state_nxt = ZERO_RUN;
          end else begin
            state_nxt = AC_MAG;
          end
        end
      end

      DC_MAG: begin
        if (take) begin
          mag_nxt     = shifted[9:0];
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (last_bit) begin
            pred_nxt  = dc_sum;
            cv_nxt    = 1'b1;
            ci_nxt    = 6'd0;
            cval_nxt  = dc_sum;
            k_nxt     = 6'd1;
            state_nxt = AC_SYM;
          end
        end
      end

      AC_MAG: begin
        if (take) begin
          mag_nxt     = shifted[9:0];
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (last_bit) begin
            cv_nxt   = 1'b1;
            ci_nxt   = k;
            cval_nxt = mag_val;
            if (k == 6'd63) begin
              bd_nxt    = 1'b1;
              k_nxt     = 6'd0;
              state_nxt = DC_SYM;
            end else begin
              k_nxt     = k + 6'd1;
              state_nxt = AC_SYM;
            end
          end
        end
      end

      ZERO_RUN: begin
        cv_nxt   = 1'b1;
        ci_nxt   = k;
        cval_nxt = '0;
        zrem_nxt = zrem - 5'd1;
        if (k == 6'd63) begin
          // Only a zero-size run can reach 63; a sized run stops at 62 or below.
          bd_nxt    = 1'b1;
          k_nxt     = 6'd0;
          state_nxt = DC_SYM;
        end else begin
          k_nxt = k + 6'd1;
          if (zrem == 5'd1) state_nxt = (sym_r == 4'd0) ? AC_SYM : AC_MAG;
        end
      end

      EOB_FILL: begin
        cv_nxt   = 1'b1;
        ci_nxt   = k;
        cval_nxt = '0;
        if (k == 6'd63) begin
          bd_nxt    = 1'b1;
          k_nxt     = 6'd0;
          state_nxt = DC_SYM;
        end else begin
          k_nxt = k + 6'd1;
        end
      end

      ERROR: begin
        state_nxt = ERROR;
      end

      default: begin
        state_nxt = ERROR;
        err_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DC_SYM;
      k          <= '0;
      pred       <= '0;
      sym_r      <= '0;
      mag        <= '0;
      bit_cnt    <= '0;
      zrem       <= '0;
      coef_valid <= 1'b0;
      coef_index <= '0;
      coef_value <= '0;
      block_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      pred       <= pred_nxt;
      sym_r      <= sym_r_nxt;
      mag        <= mag_nxt;
      bit_cnt    <= bit_cnt_nxt;
      zrem       <= zrem_nxt;
      coef_valid <= cv_nxt;
      coef_index <= ci_nxt;
      coef_value <= cval_nxt;
      block_done <= bd_nxt;
      error      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_coefficient_decoder.sv
module tb_coefficient_decoder;

  localparam int COEF_W = 12;

  localparam logic [2:0] ST_DC_SYM = 3'd0;
  localparam logic [2:0] ST_AC_SYM = 3'd1;
  localparam logic [2:0] ST_AC_MAG = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     next_bit = 1'b0;
  logic                     is_new = 1'b0;
  logic                     bit_ready;
  logic                     huff_bit_en;
  logic                     ac_dc_flag;
  logic                     huff_done = 1'b0;
  logic [3:0]               huff_s = 4'd0;
  logic [3:0]               huff_r = 4'd0;
  logic                     dc_pred_clr = 1'b0;
  logic                     coef_valid;
  logic [5:0]               coef_index;
  logic signed [COEF_W-1:0] coef_value;
  logic                     block_done;
  logic                     error;
  logic [2:0]               state_dbg;

  coefficient_decoder #(.COEF_W(COEF_W)) dut (
    .clk(clk), .rst(rst), .next_bit(next_bit), .is_new(is_new),
    .bit_ready(bit_ready), .huff_bit_en(huff_bit_en), .ac_dc_flag(ac_dc_flag),
    .huff_done(huff_done), .huff_s(huff_s), .huff_r(huff_r),
    .dc_pred_clr(dc_pred_clr), .coef_valid(coef_valid),
    .coef_index(coef_index), .coef_value(coef_value),
    .block_done(block_done), .error(error), .state_dbg(state_dbg)
  );

  // coefficient capture
  typedef struct {
    int idx;
    int val;
    bit bd;
    int cyc;
  } coef_rec_t;

  coef_rec_t got_q[$];
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    coef_rec_t rec;
    if (!rst && coef_valid) begin
      rec.idx = int'(coef_index);
      rec.val = int'(coef_value);
      rec.bd  = block_done;
      rec.cyc = cyc;
      got_q.push_back(rec);
    end
  end

  // scoreboard counters
  int total  = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    fails++;
    $error("FAIL %s: timeout waiting on DUT", tag);
  endtask

  // driver tasks (called at negedge; inputs change at negedge)
  task automatic wait_state(input logic [2:0] st, input string tag);
    int n = 0;
    while (state_dbg !== st && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (state_dbg !== st) timeout_fail(tag);
  endtask

  task automatic send_sym(input logic [3:0] s, input logic [3:0] r,
                          input logic [2:0] st, input string tag);
    wait_state(st, tag);
    is_new    = 1'b1;
    huff_done = 1'b1;
    huff_s    = s;
    huff_r    = r;
    @(negedge clk);
    is_new    = 1'b0;
    huff_done = 1'b0;
  endtask

  task automatic send_bit(input logic b, input string tag);
    int n = 0;
    while (bit_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bit_ready !== 1'b1) timeout_fail(tag);
    is_new   = 1'b1;
    next_bit = b;
    @(negedge clk);
    is_new   = 1'b0;
  endtask

  task automatic pop_coef(output coef_rec_t rec, input string tag);
    int n = 0;
    while (got_q.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      timeout_fail(tag);
      rec.idx = -1;
      rec.val = -9999;
      rec.bd  = 1'b0;
      rec.cyc = -1;
    end else begin
      rec = got_q.pop_front();
    end
  endtask

  task automatic expect_coef(input int idx, input int val, input bit bd,
                             input string tag);
    coef_rec_t rec;
    pop_coef(rec, tag);
    check({tag, ".idx"}, rec.idx, idx);
    check({tag, ".val"}, rec.val, val);
    check({tag, ".bd"}, 32'(rec.bd), 32'(bd));
  endtask

  task automatic expect_zeros(input int lo, input int hi, input string tag);
    coef_rec_t rec;
    int ok = 1;
    for (int i = lo; i <= hi; i++) begin
      pop_coef(rec, tag);
      if (rec.idx != i || rec.val != 0 || rec.bd != (i == 63)) ok = 0;
    end
    check(tag, ok, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".state"}, 32'(state_dbg), 32'(ST_DC_SYM));
    check({tag, ".coef_valid"}, 32'(coef_valid), 0);
    check({tag, ".coef_index"}, 32'(coef_index), 0);
    check({tag, ".coef_value"}, 32'(coef_value), 0);
    check({tag, ".block_done"}, 32'(block_done), 0);
    check({tag, ".error"}, 32'(error), 0);
    check({tag, ".ac_dc_flag"}, 32'(ac_dc_flag), 1);
    check({tag, ".bit_ready"}, 32'(bit_ready), 1);
  endtask

  initial begin
    coef_rec_t r1, r2, r3;

    // reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // block 1: DC r=3 bits 101 -> +5 (predictor 0)
    is_new = 1'b1; huff_done = 1'b1; huff_s = 4'd0; huff_r = 4'd3;
    #1;
    check("dc_sym.huff_bit_en", 32'(huff_bit_en), 1);
    check("dc_sym.ac_dc_flag", 32'(ac_dc_flag), 1);
    @(negedge clk);
    huff_done = 1'b0; next_bit = 1'b1;
    #1;
    check("dc_mag.huff_bit_en", 32'(huff_bit_en), 0);
    check("dc_mag.bit_ready", 32'(bit_ready), 1);
    @(negedge clk);
    is_new = 1'b0;
    send_bit(1'b0, "b1.bit2");
    send_bit(1'b1, "b1.bit3");
    expect_coef(0, 5, 1'b0, "b1.dc");

    // AC s=2 r=1 bit 0 -> zeros k1,k2 then -1 at k3 on consecutive cycles
    send_sym(4'd2, 4'd1, ST_AC_SYM, "b1.ac_s2");
    check("zrun.bit_ready", 32'(bit_ready), 0);
    check("zrun.ac_dc_flag", 32'(ac_dc_flag), 0);
    send_bit(1'b0, "b1.ac_bit");
    pop_coef(r1, "b1.z1");
    pop_coef(r2, "b1.z2");
    pop_coef(r3, "b1.v3");
    check("run.k1", r1.idx * 10000 + r1.val, 10000);
    check("run.k2", r2.idx * 10000 + r2.val, 20000);
    check("run.k3_idx", r3.idx, 3);
    check("run.k3_val", r3.val, -1);
    check("run.consec12", r2.cyc - r1.cyc, 1);
    check("run.consec23", r3.cyc - r2.cyc, 1);

    // EOB at k=4 -> zeros 4..63, block_done at 63, back to DC table
    send_sym(4'd0, 4'd0, ST_AC_SYM, "b1.eob");
    expect_zeros(4, 63, "b1.eob_fill");
    wait_state(ST_DC_SYM, "b1.to_dc");
    check("b1.end.ac_dc_flag", 32'(ac_dc_flag), 1);

    // block 2: DC r=2 bits 01 -> diff -2, value +3
    send_sym(4'd0, 4'd2, ST_DC_SYM, "b2.dc");
    send_bit(1'b0, "b2.bit1");
    send_bit(1'b1, "b2.bit2");
    expect_coef(0, 3, 1'b0, "b2.dc");
    // ZRL at k=1 -> zeros 1..16, then s=0 r=4 bits 1111 -> +15 at k=17
    send_sym(4'd15, 4'd0, ST_AC_SYM, "b2.zrl");
    send_sym(4'd0, 4'd4, ST_AC_SYM, "b2.ac17");
    for (int i = 0; i < 4; i++) send_bit(1'b1, "b2.mag");
    expect_zeros(1, 16, "b2.zrl_zeros");
    expect_coef(17, 15, 1'b0, "b2.k17");
    send_sym(4'd0, 4'd0, ST_AC_SYM, "b2.eob");
    expect_zeros(18, 63, "b2.eob_fill");

    // block 3: DC r=0 -> predictor 3; walk k to 60, then an illegal run
    send_sym(4'd0, 4'd0, ST_DC_SYM, "b3.dc");
    expect_coef(0, 3, 1'b0, "b3.dc");
    for (int i = 0; i < 3; i++) send_sym(4'd15, 4'd0, ST_AC_SYM, "b3.zrl");
    send_sym(4'd10, 4'd1, ST_AC_SYM, "b3.s10");
    send_bit(1'b1, "b3.bit");
    expect_zeros(1, 58, "b3.zeros");
    expect_coef(59, 1, 1'b0, "b3.k59");
    send_sym(4'd10, 4'd1, ST_AC_SYM, "b3.bad");
    @(negedge clk);
    check("err.error", 32'(error), 1);
    check("err.bit_ready", 32'(bit_ready), 0);
    check("err.state", 32'(state_dbg), 32'(ST_ERROR));
    is_new = 1'b1; huff_done = 1'b1; huff_s = 4'd0; huff_r = 4'd0;
    repeat (8) @(negedge clk);
    is_new = 1'b0; huff_done = 1'b0;
    check("err.no_coef", got_q.size(), 0);
    check("err.sticky", 32'(error), 1);

    // reset clears error and predictor
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_after_err");
    rst = 1'b0;
    @(negedge clk);

    // block 4: DC r=3 bits 111 -> +7 from a zeroed predictor
    send_sym(4'd0, 4'd3, ST_DC_SYM, "b4.dc");
    for (int i = 0; i < 3; i++) send_bit(1'b1, "b4.mag");
    expect_coef(0, 7, 1'b0, "b4.dc");
    send_sym(4'd0, 4'd0, ST_AC_SYM, "b4.eob");
    expect_zeros(1, 63, "b4.eob_fill");

    // block 5: clear predictor, DC r=1 bit 1 -> +1 (not +8)
    wait_state(ST_DC_SYM, "b5.wait");
    dc_pred_clr = 1'b1;
    @(negedge clk);
    dc_pred_clr = 1'b0;
    send_sym(4'd0, 4'd1, ST_DC_SYM, "b5.dc");
    send_bit(1'b1, "b5.bit");
    expect_coef(0, 1, 1'b0, "b5.dc");

    // reset mid AC_MAG
    send_sym(4'd0, 4'd2, ST_AC_SYM, "b5.ac");
    send_bit(1'b1, "b5.acbit");
    check("b5.in_ac_mag", 32'(state_dbg), 32'(ST_AC_MAG));
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid_mag");
    rst = 1'b0;
    @(negedge clk);
    check("b5.no_partial", got_q.size(), 0);

    // predictor was 1 before reset; DC r=0 must now give 0
    send_sym(4'd0, 4'd0, ST_DC_SYM, "b6.dc");
    expect_coef(0, 0, 1'b0, "b6.dc");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
